// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch front end: fetch FSM states,
// PC width/increment and the HLT opcode recognised by decode.
package fetch_sequencer_pkg;

  localparam int PC_W = 16;
  localparam logic [PC_W-1:0] PC_INCR = 16'd2;
  localparam logic [PC_W-1:0] HLT_OPCODE = 16'hF000;

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DROP,
    S_HALT
  } fetch_state_e;

  function automatic logic [15:0] sat_inc(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/fetch_sequencer_perf_counters.sv
// Saturating fetch/stall/redirect event counters for the fetch front end.
// Only present when FETCH_PERF_EN is defined.
`ifdef FETCH_PERF_EN
module fetch_perf_counters
  import fetch_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  input  logic        redirect_inc_i,
  output logic [15:0] fetch_cnt_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] redirect_cnt_o
);

  logic [15:0] fetchCnt_q;
  logic [15:0] stallCnt_q;
  logic [15:0] redirectCnt_q;

  // Each counter sticks at all-ones instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetchCnt_q    <= '0;
      stallCnt_q    <= '0;
      redirectCnt_q <= '0;
    end else begin
      if (fetch_inc_i)    fetchCnt_q    <= sat_inc(fetchCnt_q);
      if (stall_inc_i)    stallCnt_q    <= sat_inc(stallCnt_q);
      if (redirect_inc_i) redirectCnt_q <= sat_inc(redirectCnt_q);
    end
  end

  assign fetch_cnt_o    = fetchCnt_q;
  assign stall_cnt_o    = stallCnt_q;
  assign redirect_cnt_o = redirectCnt_q;

endmodule
`endif

// File: rtl/fetch_sequencer.sv
// Fetch front end: owns the PC, sequences variable-latency memory requests and
// feeds decode through a one-entry output register. FETCH_PERF_EN adds counters.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INCR  = fetch_sequencer_pkg::PC_INCR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [15:0] redirect_pc_i,
  input  logic        halt_i,
  output logic        mem_req_o,
  output logic [15:0] mem_addr_o,
  input  logic        mem_ready_i,
  input  logic [15:0] mem_rdata_i,
  output logic        instr_valid_o,
  output logic [15:0] instr_o,
  output logic [15:0] instr_pc_o,
  output logic        flush_o,
  output logic        halted_o
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] fetch_cnt_o,
  output logic [15:0] stall_cnt_o,
  output logic [15:0] redirect_cnt_o
`endif
);

  import fetch_sequencer_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] dropAddr_q, dropAddr_d;
  logic [PC_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0] instrPc_q, instrPc_d;
  logic            instrValid_q, instrValid_d;

  logic            consumed;
  logic            outFree;
  logic            memReq;
  logic [PC_W-1:0] memAddr;
  logic            load;
  logic            redirectTaken;

  assign consumed = instrValid_q && !stall_i;
  assign outFree  = !instrValid_q || consumed;

  // A new fetch starts only when the output slot frees, so at most one
  // request is ever in flight and halt never has to cancel one.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    dropAddr_d    = dropAddr_q;
    instr_d       = instr_q;
    instrPc_d     = instrPc_q;
    instrValid_d  = consumed ? 1'b0 : instrValid_q;
    memReq        = 1'b0;
    memAddr       = pc_q;
    load          = 1'b0;
    redirectTaken = 1'b0;

    case (state_q)
      S_RUN: begin
        memReq = outFree && !redirect_i && !(halt_i && consumed);
        if (redirect_i) begin
          redirectTaken = 1'b1;
        end else if (halt_i && consumed) begin
          state_d = S_HALT;
        end else if (memReq) begin
          if (mem_ready_i) load = 1'b1;
          else             state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        memReq = 1'b1;
        if (redirect_i) begin
          redirectTaken = 1'b1;
          if (mem_ready_i) begin
            state_d = S_RUN;
          end else begin
            dropAddr_d = pc_q;
            state_d    = S_DROP;
          end
        end else if (mem_ready_i) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_DROP: begin
        memReq  = 1'b1;
        memAddr = dropAddr_q;
        if (redirect_i)  redirectTaken = 1'b1;
        if (mem_ready_i) state_d = S_RUN;
      end
      default: begin
      end
    endcase

    if (load) begin
      instr_d      = mem_rdata_i;
      instrPc_d    = pc_q;
      instrValid_d = 1'b1;
      pc_d         = pc_q + PC_INCR;
    end
    if (redirectTaken) begin
      pc_d         = redirect_pc_i;
      instrValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_RUN;
      pc_q         <= RESET_PC;
      dropAddr_q   <= '0;
      instr_q      <= '0;
      instrPc_q    <= '0;
      instrValid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dropAddr_q   <= dropAddr_d;
      instr_q      <= instr_d;
      instrPc_q    <= instrPc_d;
      instrValid_q <= instrValid_d;
    end
  end

  assign mem_req_o     = memReq && !rst_i;
  assign mem_addr_o    = memAddr;
  assign instr_valid_o = instrValid_q;
  assign instr_o       = instr_q;
  assign instr_pc_o    = instrPc_q;
  assign flush_o       = redirectTaken;
  assign halted_o      = (state_q == S_HALT);

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .fetch_inc_i    (consumed),
    .stall_inc_i    (instrValid_q && stall_i),
    .redirect_inc_i (redirectTaken),
    .fetch_cnt_o    (fetch_cnt_o),
    .stall_cnt_o    (stall_cnt_o),
    .redirect_cnt_o (redirect_cnt_o)
  );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a wait-state memory model, directed
// stimulus pushing expected fetch PCs, and a monitor checking every consumed instr.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPc = 16'h0000;
  logic        halt = 1'b0;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memReady;
  logic [15:0] memRdata;
  logic        instrValid;
  logic [15:0] instr;
  logic [15:0] instrPc;
  logic        flush;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [15:0] fetchCnt;
  logic [15:0] stallCnt;
  logic [15:0] redirectCnt;
`endif

  int          testsRun = 0;
  int          failCount = 0;
  int          memWait = 0;
  int          waitCnt;
  logic [15:0] expQ[$];
  logic        prevPending = 1'b0;
  logic [15:0] prevAddr = 16'h0000;

  fetch_sequencer dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirectPc),
    .halt_i        (halt),
    .mem_req_o     (memReq),
    .mem_addr_o    (memAddr),
    .mem_ready_i   (memReady),
    .mem_rdata_i   (memRdata),
    .instr_valid_o (instrValid),
    .instr_o       (instr),
    .instr_pc_o    (instrPc),
    .flush_o       (flush),
    .halted_o      (halted)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt_o    (fetchCnt),
    .stall_cnt_o    (stallCnt),
    .redirect_cnt_o (redirectCnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: HLT sits at 0x000A, every other word is address-derived.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    if (a == 16'h000A) return HLT_OPCODE;
    return a ^ 16'hC3A5;
  endfunction

  assign memReady = memReq && (waitCnt == memWait);
  assign memRdata = memReady ? memWord(memAddr) : 16'hDEAD;

  always @(posedge clk or posedge rst) begin
    if (rst)                       waitCnt <= 0;
    else if (memReq && !memReady)  waitCnt <= waitCnt + 1;
    else                           waitCnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [15:0] rpc, input logic h);
    stall      = s;
    redirect   = r;
    redirectPc = rpc;
    halt       = h;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    tick(2);
    rst = 1'b0;
  endtask

  // Monitor: address stability of outstanding requests and in-order delivery.
  always @(negedge clk) begin
    if (rst) begin
      prevPending = 1'b0;
    end else begin
      if (prevPending) begin
        checkOutput("addrHold", memAddr, prevAddr);
        checkOutput("reqHold", {15'd0, memReq}, 16'd1);
      end
      prevPending = memReq && !memReady;
      prevAddr    = memAddr;
      if (instrValid && !stall) begin
        if (expQ.size() == 0) begin
          testsRun++;
          failCount++;
          $display("[TB] FAIL unexpectedInstr: got pc %h, expected none", instrPc);
        end else begin
          logic [15:0] e;
          e = expQ.pop_front();
          checkOutput("instrPc", instrPc, e);
          checkOutput("instrWord", instr, memWord(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    checkOutput("rstValid", {15'd0, instrValid}, 16'd0);
    checkOutput("rstInstr", instr, 16'h0000);
    checkOutput("rstInstrPc", instrPc, 16'h0000);
    checkOutput("rstHalted", {15'd0, halted}, 16'd0);
    checkOutput("rstMemReq", {15'd0, memReq}, 16'd0);
    tick(1);
    rst = 1'b0;

    // Zero-wait streaming with a four-cycle stall on pc 0x0004.
    foreach (expQ[i]) ;
    expQ.push_back(16'h0000); expQ.push_back(16'h0002);
    expQ.push_back(16'h0004); expQ.push_back(16'h0006);
    @(negedge clk);
    checkOutput("A.validBeforeFirst", {15'd0, instrValid}, 16'd0);
    checkOutput("A.firstAddr", memAddr, 16'h0000);
    tick(1);
    @(negedge clk);
    checkOutput("A.firstValid", {15'd0, instrValid}, 16'd1);
    tick(2);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("A.stallReq", {15'd0, memReq}, 16'd0);
      checkOutput("A.stallPc", instrPc, 16'h0004);
      tick(1);
    end
    stall = 1'b0;
    @(negedge clk);
    checkOutput("A.resumeAddr", memAddr, 16'h0006);
    tick(2);
    stall = 1'b1;
    @(negedge clk);
    checkOutput("A.heldPc", instrPc, 16'h0008);
    checkOutput("A.drained", expQ.size(), 16'd0);

    // Two-wait memory: each address held for three cycles.
    memWait = 2;
    resetDut();
    expQ.push_back(16'h0000); expQ.push_back(16'h0002);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("B.addr0", memAddr, 16'h0000);
      checkOutput("B.valid0", {15'd0, instrValid}, 16'd0);
      tick(1);
    end
    @(negedge clk);
    checkOutput("B.pulse0", {15'd0, instrValid}, 16'd1);
    tick(1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("B.gap", {15'd0, instrValid}, 16'd0);
      checkOutput("B.addr2", memAddr, 16'h0002);
      tick(1);
    end
    @(negedge clk);
    checkOutput("B.pulse2", {15'd0, instrValid}, 16'd1);
    tick(1);
    checkOutput("B.drained", expQ.size(), 16'd0);

    // Redirect during an outstanding three-wait request to 0x0008.
    memWait = 0;
    resetDut();
    expQ.push_back(16'h0000); expQ.push_back(16'h0002); expQ.push_back(16'h0004);
    expQ.push_back(16'h0006); expQ.push_back(16'h0100);
    tick(4);
    memWait = 3;
    @(negedge clk);
    checkOutput("D.reqAddr", memAddr, 16'h0008);
    tick(1);
    applyStimulus(1'b0, 1'b1, 16'h0100, 1'b0);
    @(negedge clk);
    checkOutput("D.flush", {15'd0, flush}, 16'd1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("D.flushOff", {15'd0, flush}, 16'd0);
      checkOutput("D.dropAddr", memAddr, 16'h0008);
      tick(1);
    end
    @(negedge clk);
    checkOutput("D.newAddr", memAddr, 16'h0100);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(1);
      @(negedge clk);
      if (instrValid) seen = 1'b1;
    end
    checkOutput("D.arrived", {15'd0, seen}, 16'd1);
    tick(1);
    checkOutput("D.drained", expQ.size(), 16'd0);

    // Halt on 0x000A, redirect ignored while halted.
    memWait = 0;
    resetDut();
    expQ.push_back(16'h0000); expQ.push_back(16'h0002); expQ.push_back(16'h0004);
    expQ.push_back(16'h0006); expQ.push_back(16'h0008); expQ.push_back(16'h000A);
    tick(6);
    halt = 1'b1;
    @(negedge clk);
    checkOutput("E.hltWord", instr, HLT_OPCODE);
    checkOutput("E.noReqOnHalt", {15'd0, memReq}, 16'd0);
    tick(1);
    halt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("E.halted", {15'd0, halted}, 16'd1);
      checkOutput("E.memReq", {15'd0, memReq}, 16'd0);
      tick(1);
    end
    applyStimulus(1'b0, 1'b1, 16'h0040, 1'b0);
    @(negedge clk);
    checkOutput("E.flushIgnored", {15'd0, flush}, 16'd0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("E.stillHalted", {15'd0, halted}, 16'd1);
      checkOutput("E.noValid", {15'd0, instrValid}, 16'd0);
      checkOutput("E.stillNoReq", {15'd0, memReq}, 16'd0);
      tick(1);
    end
    checkOutput("E.drained", expQ.size(), 16'd0);

    // Restart after reset, then redirect to 0xFFFE and wrap to 0x0000.
    resetDut();
    expQ.push_back(16'h0000); expQ.push_back(16'hFFFE); expQ.push_back(16'h0000);
    @(negedge clk);
    checkOutput("F.unhalted", {15'd0, halted}, 16'd0);
    checkOutput("F.restartAddr", memAddr, 16'h0000);
    tick(1);
    applyStimulus(1'b0, 1'b1, 16'hFFFE, 1'b0);
    @(negedge clk);
    checkOutput("F.flush", {15'd0, flush}, 16'd1);
    checkOutput("F.noReqOnRedirect", {15'd0, memReq}, 16'd0);
    tick(1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
    @(negedge clk);
    checkOutput("F.topAddr", memAddr, 16'hFFFE);
    tick(1);
    @(negedge clk);
    checkOutput("F.wrapAddr", memAddr, 16'h0000);
    tick(2);
    stall = 1'b1;
    @(negedge clk);
    checkOutput("F.afterWrapPc", instrPc, 16'h0002);
    checkOutput("F.drained", expQ.size(), 16'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Controls the instruction-fetch front end of the 16-bit processor.
- Owns the PC register and sequences requests to a variable-latency instruction memory using a req/ready handshake.
- Presents fetched instructions to decode through a single-entry output register with a valid/stall handshake.
- Applies taken-branch redirects (flushing wrong-path fetches) and freezes fetch on HLT.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- PC_INCR, 2: byte increment per sequential fetch.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- stall  in  1  decode cannot accept instr this cycle.
- redirect  in  1  taken branch/jump resolved this cycle.
- redirect_pc  in  16  target address, valid with redirect.
- halt  in  1  the instr currently presented is HLT; qualified by instr_valid.
- mem_req  out  1  instruction-memory request.
- mem_addr  out  16  request address; held stable while mem_req && !mem_ready.
- mem_ready  in  1  memory completes the request this cycle; may coincide with the first mem_req cycle.
- mem_rdata  in  16  instruction word, valid with mem_ready.
- instr_valid  out  1  instr/instr_pc valid.
- instr  out  16  fetched instruction.
- instr_pc  out  16  address of instr.
- flush  out  1  wrong-path squash, combinational.
- halted  out  1  fetch stopped by HLT.

Behaviour:
- Reset (asynchronous, whole block):
  - pc=RESET_PC, state=S_RUN.
  - instr_valid=0, instr=0, instr_pc=0, halted=0.
  - mem_req forced 0 while rst=1.
- Consume: the output is consumed in a cycle where instr_valid && !stall.
- States:
  - S_RUN: no request outstanding.
  - S_WAIT: request outstanding.
  - S_DROP: outstanding request is wrong-path and will be discarded.
  - S_HALT: fetch stopped.
- S_RUN:
  - mem_req=1, mem_addr=pc when (!instr_valid || consumed) && !redirect && !(halt && consumed).
  - If the request completes in the same cycle: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_INCR; stay in S_RUN.
  - Otherwise go to S_WAIT.
  - If no request is issued and the output is consumed: instr_valid<=0.
- S_WAIT:
  - mem_req=1, mem_addr=pc held.
  - On mem_ready: load the output register as above, pc+=PC_INCR, go to S_RUN.
- Redirect (priority over halt/stall, ignored in S_HALT):
  - flush=redirect in the same cycle.
  - pc<=redirect_pc; instr_valid<=0.
  - Data completing in this cycle is discarded.
  - If a request is outstanding and not completing: latch drop_addr=pc, go to S_DROP.
- S_DROP:
  - mem_req=1, mem_addr=drop_addr.
  - On mem_ready: discard data, go to S_RUN; the next request uses the redirected pc.
  - A further redirect in S_DROP updates pc only.
- Halt:
  - When consumed && halt && !redirect: instr_valid<=0, go to S_HALT.
  - No request is issued in that cycle. No request can be outstanding, because requests start only when the output frees.
- S_HALT:
  - halted=1, mem_req=0, pc frozen.
  - Exit only via rst.
- Arithmetic: pc+PC_INCR wraps modulo 2^16 (16'hFFFE -> 16'h0000).
- Throughput: a zero-wait memory (ready in the request cycle) sustains 1 instr/cycle; an N-wait memory sustains 1 instr per N+1 cycles.
- Stall: holds instr/instr_pc/instr_valid unchanged and blocks new requests. It never affects a request already outstanding.
- Reset mid-request: the request is abandoned. The memory must tolerate mem_req dropping.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs fetch_cnt[15:0], stall_cnt[15:0], redirect_cnt[15:0]. All are saturating at 16'hFFFF and cleared by rst.
  - fetch_cnt: +1 per consumed instr.
  - stall_cnt: +1 per cycle with instr_valid && stall.
  - redirect_cnt: +1 per accepted redirect.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - fetch state enum (S_RUN, S_WAIT, S_DROP, S_HALT).
  - PC width constant 16.
  - PC_INCR.
  - HLT opcode constant (used by decode and the bench).
- Sub-module fetch_perf_counters: holds the three saturating counters, instantiated only under FETCH_PERF_EN.

Test Plan:
- Zero-wait memory, mem_ready tied high, no stall: after reset release, instr_pc sequence is 0x0000, 0x0002, 0x0004… on consecutive cycles. instr_valid first rises 1 cycle after rst falls.
- 2-wait memory: mem_addr=0x0000 held 3 cycles. instr_valid pulses with instr_pc=0x0000, then 0x0002, 3 cycles apart.
- Hold stall=1 for 4 cycles with instr_pc=0x0004 valid: instr held, mem_req=0 throughout. Release: next instr_pc=0x0006.
- 3-wait memory, redirect to 0x0100 one cycle after a request to 0x0008 starts: flush=1 for 1 cycle, and mem_addr stays 0x0008 until ready. That data is never presented; the next mem_addr is 0x0100 and the next instr_pc is 0x0100.
- Halt asserted with instr_pc=0x000A consumed: halted=1 next cycle, mem_req=0 forever. A later redirect is ignored. rst restarts fetch at 0x0000.
- Wrap: redirect to 0xFFFE, zero-wait: instr_pc 0xFFFE then 0x0000.
